// File: rtl/cvxif_copro_responder.sv
// Coprocessor side of the CV-X-IF offload interface: decodes custom-0 ALU ops,
// tracks outstanding instructions in an in-order queue and returns results in issue order.
module cvxif_copro_responder #(
  parameter int DEPTH = 4,
  parameter int IdW   = 3,
  parameter int XLEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_issue_valid_i,
  output logic            x_issue_ready_o,
  input  logic [31:0]     x_issue_instr_i,
  input  logic [IdW-1:0]  x_issue_id_i,
  output logic            x_issue_accept_o,
  output logic            x_issue_writeback_o,
  input  logic            x_register_valid_i,
  output logic            x_register_ready_o,
  input  logic [IdW-1:0]  x_register_id_i,
  input  logic [XLEN-1:0] x_register_rs1_i,
  input  logic [XLEN-1:0] x_register_rs2_i,
  input  logic            x_commit_valid_i,
  input  logic [IdW-1:0]  x_commit_id_i,
  input  logic            x_commit_kill_i,
  output logic            x_result_valid_o,
  input  logic            x_result_ready_i,
  output logic [IdW-1:0]  x_result_id_o,
  output logic [XLEN-1:0] x_result_data_o,
  output logic [4:0]      x_result_rd_o,
  output logic            x_result_we_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DEPTH_CNT = (PtrW+1)'(DEPTH);
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    F3_ADD = 3'b000,
    F3_SUB = 3'b001,
    F3_XOR = 3'b010,
    F3_NOP = 3'b100
  } funct3_e;

  logic [DEPTH-1:0] ent_v, ent_ops, ent_com, ent_kill;
  logic [IdW-1:0]   ent_id  [DEPTH];
  logic [4:0]       ent_rd  [DEPTH];
  logic [2:0]       ent_f3  [DEPTH];
  logic [XLEN-1:0]  ent_rs1 [DEPTH];
  logic [XLEN-1:0]  ent_rs2 [DEPTH];

  logic [PtrW-1:0] head, tail;
  logic [PtrW:0]   count;

  logic            res_valid;
  logic [IdW-1:0]  res_id;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_rd;

  logic [6:0] dec_opc;
  logic [2:0] dec_f3;
  logic [4:0] dec_rd;
  logic       dec_ok, dec_nop, issue_ready, issue_fire, commit_to_new;
  logic       head_v, head_live, retire_kill, retire_nop, retire_alu, retire, res_free;
  logic [XLEN-1:0] alu_result;
  logic       unused_instr_bits;

  assign dec_opc = x_issue_instr_i[6:0];
  assign dec_rd  = x_issue_instr_i[11:7];
  assign dec_f3  = x_issue_instr_i[14:12];
  assign unused_instr_bits = ^x_issue_instr_i[31:15];

  assign dec_nop = (dec_f3 == F3_NOP);
  assign dec_ok  = (dec_opc == OPC_CUSTOM0) &&
                   (dec_f3 == F3_ADD || dec_f3 == F3_SUB || dec_f3 == F3_XOR || dec_nop);

  // Reset forces the combinational handshake outputs low so every output reads 0 in reset.
  assign issue_ready         = !rst_i && (count < DEPTH_CNT);
  assign issue_fire          = x_issue_valid_i && issue_ready && dec_ok;
  assign x_issue_ready_o     = issue_ready;
  assign x_issue_accept_o    = issue_fire;
  assign x_issue_writeback_o = issue_fire && !dec_nop;
  assign x_register_ready_o  = !rst_i;

  // A commit naming the id being issued this cycle belongs to the new entry, not a stale one.
  assign commit_to_new = x_commit_valid_i && issue_fire && (x_commit_id_i == x_issue_id_i);

  assign head_v      = ent_v[head];
  assign head_live   = head_v && ent_com[head] && !ent_kill[head];
  assign res_free    = !res_valid || x_result_ready_i;
  assign retire_kill = head_v && ent_com[head] && ent_kill[head];
  assign retire_nop  = head_live && (ent_f3[head] == F3_NOP);
  assign retire_alu  = head_live && (ent_f3[head] != F3_NOP) && ent_ops[head] && res_free;
  assign retire      = retire_kill || retire_nop || retire_alu;

  always_comb begin
    alu_result = '0;
    case (ent_f3[head])
      F3_ADD:  alu_result = ent_rs1[head] + ent_rs2[head];
      F3_SUB:  alu_result = ent_rs1[head] - ent_rs2[head];
      F3_XOR:  alu_result = ent_rs1[head] ^ ent_rs2[head];
      default: alu_result = '0;
    endcase
  end

  // Queue storage: operand/commit CAM updates first, then retire, then the new issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_v    <= '0;
      ent_ops  <= '0;
      ent_com  <= '0;
      ent_kill <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_id[i]  <= '0;
        ent_rd[i]  <= '0;
        ent_f3[i]  <= '0;
        ent_rs1[i] <= '0;
        ent_rs2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_v[i] && x_register_valid_i && ent_id[i] == x_register_id_i) begin
          ent_ops[i] <= 1'b1;
          ent_rs1[i] <= x_register_rs1_i;
          ent_rs2[i] <= x_register_rs2_i;
        end
        if (ent_v[i] && x_commit_valid_i && !commit_to_new && ent_id[i] == x_commit_id_i) begin
          ent_com[i]  <= 1'b1;
          ent_kill[i] <= x_commit_kill_i;
        end
        if (retire && head == PtrW'(i)) begin
          ent_v[i] <= 1'b0;
        end
        if (issue_fire && tail == PtrW'(i)) begin
          ent_v[i]    <= 1'b1;
          ent_ops[i]  <= 1'b0;
          ent_com[i]  <= commit_to_new;
          ent_kill[i] <= commit_to_new && x_commit_kill_i;
          ent_id[i]   <= x_issue_id_i;
          ent_rd[i]   <= dec_rd;
          ent_f3[i]   <= dec_f3;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (issue_fire) tail <= tail + 1'b1;
      if (retire)     head <= head + 1'b1;
      case ({issue_fire, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result register can be consumed and refilled in the same cycle for back-to-back results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      res_rd    <= '0;
    end else if (retire_alu) begin
      res_valid <= 1'b1;
      res_id    <= ent_id[head];
      res_data  <= alu_result;
      res_rd    <= ent_rd[head];
    end else if (x_result_ready_i) begin
      res_valid <= 1'b0;
    end
  end

  assign x_result_valid_o = res_valid;
  assign x_result_id_o    = res_id;
  assign x_result_data_o  = res_data;
  assign x_result_rd_o    = res_rd;
  assign x_result_we_o    = res_valid;

endmodule
